// File: rtl/stack_ptr_ctrl.sv
// Stack-pointer controller: SP register, depth counter, push/pop/load decode, full/empty and sticky fault trap.
// Optional high-water-mark output enabled by defining SP_WATERMARK_EN.
module stack_ptr_ctrl #(
    parameter int SP_W  = 5,
    parameter int DEPTH = 32,
    parameter int TOP   = 31
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            load,
    input  logic [SP_W-1:0] load_val,
    input  logic            clr_fault,
    output logic [SP_W-1:0] sp,
    output logic [SP_W-1:0] addr,
    output logic            we,
    output logic [SP_W:0]   count,
    output logic            full,
    output logic            empty,
    output logic            ovf,
    output logic            unf,
    output logic            fault
`ifdef SP_WATERMARK_EN
    ,
    output logic [SP_W:0]   hwm
`endif
);

    localparam logic [SP_W-1:0] TOP_V   = SP_W'(TOP);
    localparam logic [SP_W:0]   DEPTH_V = (SP_W+1)'(DEPTH);
    localparam logic [SP_W-1:0] ONE_SP  = SP_W'(1);
    localparam logic [SP_W:0]   ONE_CNT = (SP_W+1)'(1);

    typedef enum logic {RUN, FAULT} state_t;

    state_t          state_q, state_d;
    logic [SP_W-1:0] sp_q, sp_d;
    logic [SP_W:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            we_c;
    logic [SP_W-1:0] sp_inc, sp_dec, load_dist;
    logic            full_c, empty_c;

    assign sp_inc    = sp_q + ONE_SP;
    assign sp_dec    = sp_q - ONE_SP;
    assign load_dist = TOP_V - load_val;
    // Flags come from the counter, never from sp, so a wrapped sp cannot alias full with empty.
    assign full_c    = (count_q == DEPTH_V);
    assign empty_c   = (count_q == '0);

    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        addr    = sp_q;
        we_c    = 1'b0;
        if (state_q == RUN) begin
            if (load) begin
                addr = load_val;
                if ({1'b0, load_dist} <= DEPTH_V) begin
                    sp_d    = load_val;
                    count_d = {1'b0, load_dist};
                end else begin
                    ovf_d   = 1'b1;
                    state_d = FAULT;
                end
            end else if (push && pop) begin
                // Replace-top: rewrite the most recent entry in place.
                addr = sp_inc;
                if (empty_c) begin
                    unf_d   = 1'b1;
                    state_d = FAULT;
                end else begin
                    we_c = 1'b1;
                end
            end else if (push) begin
                if (full_c) begin
                    ovf_d   = 1'b1;
                    state_d = FAULT;
                end else begin
                    we_c    = 1'b1;
                    sp_d    = sp_dec;
                    count_d = count_q + ONE_CNT;
                end
            end else if (pop) begin
                addr = sp_inc;
                if (empty_c) begin
                    unf_d   = 1'b1;
                    state_d = FAULT;
                end else begin
                    sp_d    = sp_inc;
                    count_d = count_q - ONE_CNT;
                end
            end
        end else if (clr_fault) begin
            state_d = RUN;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            sp_q    <= TOP_V;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

`ifdef SP_WATERMARK_EN
    // count only rises on an accepted push or load, so tracking max(next count) covers both.
    logic [SP_W:0] hwm_q, hwm_d;

    always_comb begin
        hwm_d = hwm_q;
        if (count_d > hwm_q) hwm_d = count_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hwm_q <= '0;
        else     hwm_q <= hwm_d;
    end

    assign hwm = hwm_q;
`endif

    assign sp    = sp_q;
    assign count = count_q;
    assign we    = we_c & ~rst;
    assign full  = full_c;
    assign empty = empty_c;
    assign ovf   = ovf_q;
    assign unf   = unf_q;
    assign fault = (state_q == FAULT);

endmodule

// File: tb/tb_stack_ptr_ctrl.sv
// Scoreboard bench for stack_ptr_ctrl: directed cycles queue hand-computed expectations, a negedge monitor checks them.
module tb_stack_ptr_ctrl;

    localparam int SP_W = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            push = 1'b0, pop = 1'b0, load = 1'b0, clr_fault = 1'b0;
    logic [SP_W-1:0] load_val = '0;

    logic [SP_W-1:0] sp_a, addr_a, sp_b, addr_b;
    logic [SP_W:0]   count_a, count_b;
    logic            we_a, full_a, empty_a, ovf_a, unf_a, fault_a;
    logic            we_b, full_b, empty_b, ovf_b, unf_b, fault_b;
`ifdef SP_WATERMARK_EN
    logic [SP_W:0]   hwm_a, hwm_b;
`endif

    always #5 clk = ~clk;

    stack_ptr_ctrl #(.SP_W(SP_W), .DEPTH(32), .TOP(31)) u_a (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .load(load), .load_val(load_val),
        .clr_fault(clr_fault), .sp(sp_a), .addr(addr_a), .we(we_a), .count(count_a),
        .full(full_a), .empty(empty_a), .ovf(ovf_a), .unf(unf_a), .fault(fault_a)
`ifdef SP_WATERMARK_EN
        , .hwm(hwm_a)
`endif
    );

    stack_ptr_ctrl #(.SP_W(SP_W), .DEPTH(16), .TOP(31)) u_b (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .load(load), .load_val(load_val),
        .clr_fault(clr_fault), .sp(sp_b), .addr(addr_b), .we(we_b), .count(count_b),
        .full(full_b), .empty(empty_b), .ovf(ovf_b), .unf(unf_b), .fault(fault_b)
`ifdef SP_WATERMARK_EN
        , .hwm(hwm_b)
`endif
    );

    // kind 0: DEPTH=32 instance, kind 1: DEPTH=16 instance, kind 2: watermark of DEPTH=32 instance
    typedef struct {
        int              kind;
        string           name;
        logic [SP_W-1:0] sp;
        logic [SP_W-1:0] addr;
        logic            we;
        logic [SP_W:0]   count;
        logic            full, empty, ovf, unf, fault;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic cyc(input logic r, input logic pu, input logic po, input logic ld,
                       input int lv, input logic cl);
        @(posedge clk);
        #1;
        rst       = r;
        push      = pu;
        pop       = po;
        load      = ld;
        load_val  = SP_W'(lv);
        clr_fault = cl;
    endtask

    task automatic ex(input int kind, input string nm, input int e_sp, input int e_addr,
                      input int e_we, input int e_cnt, input int e_full, input int e_empty,
                      input int e_ovf, input int e_unf, input int e_fault);
        exp_t e;
        e.kind  = kind;
        e.name  = nm;
        e.sp    = SP_W'(e_sp);
        e.addr  = SP_W'(e_addr);
        e.we    = (e_we != 0);
        e.count = (SP_W+1)'(e_cnt);
        e.full  = (e_full != 0);
        e.empty = (e_empty != 0);
        e.ovf   = (e_ovf != 0);
        e.unf   = (e_unf != 0);
        e.fault = (e_fault != 0);
        q.push_back(e);
    endtask

    // Monitor: drains every expectation queued for the current cycle, away from the active edge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [SP_W*2+SP_W+1+6-1:0] got, want;
            e = q.pop_front();
            if (e.kind == 2) begin
`ifdef SP_WATERMARK_EN
                n_vec++;
                if (hwm_a !== e.count) begin
                    n_bad++;
                    $display("FAIL %s: hwm got %0d want %0d", e.name, hwm_a, e.count);
                end
`endif
            end else begin
                want = {e.sp, e.addr, e.we, e.count, e.full, e.empty, e.ovf, e.unf, e.fault};
                if (e.kind == 0)
                    got = {sp_a, addr_a, we_a, count_a, full_a, empty_a, ovf_a, unf_a, fault_a};
                else
                    got = {sp_b, addr_b, we_b, count_b, full_b, empty_b, ovf_b, unf_b, fault_b};
                n_vec++;
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL %s: got sp=%0d addr=%0d we=%0b cnt=%0d f/e/o/u/F=%b want sp=%0d addr=%0d we=%0b cnt=%0d f/e/o/u/F=%b",
                             e.name, got[20:16], got[15:11], got[10], got[9:5], got[4:0],
                             e.sp, e.addr, e.we, e.count, {e.full, e.empty, e.ovf, e.unf, e.fault});
                end
            end
        end
    end

    initial begin
        // Reset held with a push request: no write may escape.
        cyc(1, 1, 0, 0, 0, 0);
        ex(0, "rst_hold_a", 31, 31, 0, 0, 0, 1, 0, 0, 0);
        ex(1, "rst_hold_b", 31, 31, 0, 0, 0, 1, 0, 0, 0);

        // load_val=0: accepted at DEPTH=32 (d=31), overflow at DEPTH=16.
        cyc(0, 0, 0, 1, 0, 0);
        ex(0, "ld0_req_a", 31, 0, 0, 0, 0, 1, 0, 0, 0);
        ex(1, "ld0_req_b", 31, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        ex(0, "ld0_done_a", 0, 0, 0, 31, 0, 0, 0, 0, 0);
        ex(1, "ld0_ovf_b", 31, 31, 0, 0, 0, 1, 1, 0, 1);

        cyc(1, 0, 0, 0, 0, 0);
        ex(0, "rst2", 31, 31, 0, 0, 0, 1, 0, 0, 0);

        // Three pushes, then idle.
        cyc(0, 1, 0, 0, 0, 0); ex(0, "push1", 31, 31, 1, 0, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0); ex(0, "push2", 30, 30, 1, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0); ex(0, "push3", 29, 29, 1, 2, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0); ex(0, "after3", 28, 28, 0, 3, 0, 0, 0, 0, 0);

        // Down to count=2, then replace-top.
        cyc(0, 0, 1, 0, 0, 0); ex(0, "pop3", 28, 29, 0, 3, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0); ex(0, "repl", 29, 30, 1, 2, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0); ex(0, "repl_hold", 29, 29, 0, 2, 0, 0, 0, 0, 0);

        // Empty the stack, replace-top on empty underflows.
        cyc(0, 0, 1, 0, 0, 0); ex(0, "pop2", 29, 30, 0, 2, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0); ex(0, "pop1", 30, 31, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0); ex(0, "repl_empty", 31, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0); ex(0, "repl_unf", 31, 31, 0, 0, 0, 1, 0, 1, 1);
        cyc(0, 1, 0, 0, 0, 0); ex(0, "fault_push", 31, 31, 0, 0, 0, 1, 0, 1, 1);
        cyc(0, 1, 0, 0, 0, 1); ex(0, "clr_cyc", 31, 31, 0, 0, 0, 1, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0); ex(0, "clr_done", 31, 31, 0, 0, 0, 1, 0, 0, 0);

        // Plain pop on empty.
        cyc(0, 0, 1, 0, 0, 0); ex(0, "pop_empty", 31, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0); ex(0, "unf_push_ign", 31, 31, 0, 0, 0, 1, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 1); ex(0, "unf_clr_cyc", 31, 31, 0, 0, 0, 1, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0); ex(0, "unf_cleared", 31, 31, 0, 0, 0, 1, 0, 0, 0);

        // Loads.
        cyc(0, 0, 0, 1, 20, 0); ex(0, "ld20_req", 31, 20, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);  ex(0, "ld20_done", 20, 20, 0, 11, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 31, 0); ex(0, "ld31_req", 20, 31, 0, 11, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);  ex(0, "ld31_done", 31, 31, 0, 0, 0, 1, 0, 0, 0);

        // Fill to capacity; sp wraps back to 31 at count=32.
        for (int i = 0; i < 32; i++) begin
            cyc(0, 1, 0, 0, 0, 0);
            ex(0, "fill", (31 - i) & 31, (31 - i) & 31, 1, i, 0, (i == 0) ? 1 : 0, 0, 0, 0);
        end
        cyc(0, 1, 0, 0, 0, 0); ex(0, "push_full", 31, 31, 0, 32, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0); ex(0, "ovf_trap", 31, 31, 0, 32, 1, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 1); ex(0, "ovf_clr_cyc", 31, 31, 0, 32, 1, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 0); ex(0, "ovf_cleared", 31, 31, 0, 32, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0); ex(0, "pop_full", 31, 0, 0, 32, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0); ex(0, "after_pop", 0, 0, 0, 31, 0, 0, 0, 0, 0);

        // Reset mid-burst takes effect without a clock edge.
        cyc(1, 1, 0, 0, 0, 0); ex(0, "rst_mid", 31, 31, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0); ex(0, "pop_empty2", 31, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0); ex(0, "unf2", 31, 31, 0, 0, 0, 1, 0, 1, 1);
        cyc(1, 0, 0, 0, 0, 0); ex(0, "rst_fault", 31, 31, 0, 0, 0, 1, 0, 0, 0);

        // Five pushes, five pops.
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0, 0, 0, 0);
            ex(0, "wm_push", 31 - i, 31 - i, 1, i, 0, (i == 0) ? 1 : 0, 0, 0, 0);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, 0, 0, 0);
            ex(0, "wm_pop", 26 + i, 27 + i, 0, 5 - i, 0, 0, 0, 0, 0);
        end
        cyc(0, 0, 0, 0, 0, 0);
        ex(0, "wm_end", 31, 31, 0, 0, 0, 1, 0, 0, 0);
`ifdef SP_WATERMARK_EN
        ex(2, "hwm5", 0, 0, 0, 5, 0, 0, 0, 0, 0);
`endif

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
